motion_beat_detector: RTL
=========================

# motion_beat_detector

Downstream consumer of the MPU-6050 I2C reader's accelerometer byte registers. Snapshots the six raw accel bytes on a fixed sample tick and forms an L1 acceleration magnitude. A hysteresis/refractory state machine turns each magnitude excursion into one single-cycle `beat` pulse, with peak strength and a running beat count, for the game/audio logic.

## Interface
Parameters:
- `SAMPLE_DIV`, 500000: clk cycles per sample tick (10 ms at 50 MHz); must be ≥ 4.
- `THRESH_ON`, 18'd40000: onset threshold on magnitude.
- `THRESH_OFF`, 18'd28000: release threshold; must be < `THRESH_ON`.
- `REFRACT`, 20: samples ignored after a beat; must be ≥ 1.
- `PEAK_MAX`, 50: maximum samples spent in PEAK before a forced beat.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  asynchronous, active-low reset.
- `acc_xh`, `acc_xl`, `acc_yh`, `acc_yl`, `acc_zh`, `acc_zl`  in  8 each  raw accel bytes from the I2C reader.
- `sample_valid`  out  1  one-cycle strobe; `mag` is new.
- `mag`  out  18  |x|+|y|+|z| of the latest sample, unsigned.
- `beat`  out  1  one-cycle beat pulse.
- `beat_strength`  out  18  peak `mag` of the last beat; holds until the next beat.
- `beat_count`  out  16  beats since reset; wraps from 0xFFFF to 0.

## Operation
- Tick counter runs 0..`SAMPLE_DIV`-1 and wraps. `tick` is high in the cycle where the count equals `SAMPLE_DIV`-1.
- Stage 1 (on tick): capture x={acc_xh,acc_xl}, y, z as signed 16-bit values, all in the same edge. Byte tearing from the upstream's sequential updates is accepted.
- Stage 2: absolute values, 17-bit unsigned. abs(-32768)=32768.
- Stage 3: sum into 18 bits (maximum 98304, no overflow). Register `mag` and pulse `sample_valid`.
- The FSM evaluates only on `sample_valid`:
  - ARMED: if `mag` ≥ `THRESH_ON`, load peak←`mag`, clear the sample counter, and go to PEAK. Otherwise stay.
  - PEAK: update peak←max(peak, `mag`) and increment the sample counter. Release when `mag` < `THRESH_OFF`, or when the counter reaches `PEAK_MAX` (forced release).
  - On release: assert `beat`, set `beat_strength`←peak (including the current sample if it is larger), increment `beat_count`, clear the counter, and go to REFRACT.
  - REFRACT: increment the counter each sample. When the counter reaches `REFRACT`, go to ARMED. The sample that completes the count is not evaluated for onset.
- A magnitude between `THRESH_OFF` and `THRESH_ON` while in PEAK keeps the FSM in PEAK (hysteresis).
- Reset (async, any time, including mid-PEAK): state→ARMED. Tick counter, pipeline registers, peak and counter clear to 0. Outputs clear: `sample_valid`=0, `mag`=0, `beat`=0, `beat_strength`=0, `beat_count`=0. A beat in progress is discarded without a pulse.

## Timing
- `sample_valid` is high exactly 3 cycles after the tick cycle, for 1 cycle, once per `SAMPLE_DIV` cycles.
- First tick after reset release occurs in cycle `SAMPLE_DIV`-1.
- `beat` is high the cycle after the `sample_valid` that causes release, for exactly 1 cycle. `beat_strength` and `beat_count` update on that same edge.
- Latency from tick to `beat` is 4 cycles.
- Input bytes are sampled only at tick; changes at any other time have no effect.
- `beat` never fires on consecutive samples. The minimum spacing between beats is `REFRACT`+2 samples.

## Test plan
Use `SAMPLE_DIV`=8, `REFRACT`=3, and `PEAK_MAX`=5, with other parameters at defaults.

- Rest: x=0, y=0, z=16384 held → `mag`=16384 on every `sample_valid` (every 8 cycles, 3 cycles after tick); `beat` never asserts; `beat_count`=0.
- Single hit: `mag` sequence 16384, 45000, 60000, 50000, 20000 → one `beat` the cycle after the 20000 sample; `beat_strength`=60000; `beat_count`=1.
- Hysteresis and refractory: sequence 45000, 30000, 30000, 20000, 45000, 45000, 45000, 45000 → one beat after 20000. The first two following 45000 samples are ignored; the third completes REFRACT. The fourth re-arms to PEAK with no second beat yet.
- Negative extremes: x=y=z=16'h8000 → `mag`=98304; after 5 PEAK samples a forced `beat` fires with `beat_strength`=98304.
- Wrap and reset: preload `beat_count` to 0xFFFF via 65535 beats (or force), then one beat → `beat_count`=0. Assert `rst_n`=0 mid-PEAK → all outputs read 0 the same cycle, and no beat follows after release.

Source files
------------

// File: rtl/motion_beat_detector_if.sv
// Bus between the MPU-6050 reader's accel byte registers, the beat detector and its consumer.
// The detector takes the slave side; the game/audio logic (or a bench) takes the master side.
interface motion_beat_detector_if;
  logic [7:0]  acc_xh;
  logic [7:0]  acc_xl;
  logic [7:0]  acc_yh;
  logic [7:0]  acc_yl;
  logic [7:0]  acc_zh;
  logic [7:0]  acc_zl;
  logic        sample_valid;
  logic [17:0] mag;
  logic        beat;
  logic [17:0] beat_strength;
  logic [15:0] beat_count;

  modport master (
    output acc_xh, acc_xl, acc_yh, acc_yl, acc_zh, acc_zl,
    input  sample_valid, mag, beat, beat_strength, beat_count
  );

  modport slave (
    input  acc_xh, acc_xl, acc_yh, acc_yl, acc_zh, acc_zl,
    output sample_valid, mag, beat, beat_strength, beat_count
  );
endinterface

// File: rtl/motion_beat_detector.sv
// Samples the accel bytes on a fixed tick, forms |x|+|y|+|z| in a 3-stage pipeline and turns
// each magnitude excursion into one beat pulse via an ARMED/PEAK/REFRACT hysteresis machine.
module motion_beat_detector #(
  parameter int unsigned SAMPLE_DIV = 500000,
  parameter logic [17:0] THRESH_ON  = 18'd40000,
  parameter logic [17:0] THRESH_OFF = 18'd28000,
  parameter int unsigned REFRACT    = 20,
  parameter int unsigned PEAK_MAX   = 50
) (
  input  logic                   clk,
  input  logic                   rst_n,
  motion_beat_detector_if.slave  bus
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_PEAK    = 2'd1,
    ST_REFRACT = 2'd2
  } state_t;

  function automatic logic [16:0] abs17(input logic [15:0] v);
    logic [16:0] ext;
    ext = {v[15], v};
    // Widening first keeps abs(-32768) = 32768 representable.
    return v[15] ? (~ext + 17'd1) : ext;
  endfunction

  // ---------------------------------------------------------------- sample tick
  logic [DIV_W-1:0] tick_cnt_q;
  logic             tick;

  assign tick = (tick_cnt_q == DIV_W'(SAMPLE_DIV - 1));

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else tick_cnt_q <= tick_cnt_q + DIV_W'(1);
  end

  // ---------------------------------------------------------------- magnitude pipeline
  logic [15:0] x_q, y_q, z_q;
  logic        s1_valid_q;
  logic [16:0] ax_q, ay_q, az_q;
  logic        s2_valid_q;
  logic [17:0] mag_q;
  logic        sample_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q            <= '0;
      y_q            <= '0;
      z_q            <= '0;
      s1_valid_q     <= 1'b0;
      ax_q           <= '0;
      ay_q           <= '0;
      az_q           <= '0;
      s2_valid_q     <= 1'b0;
      mag_q          <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= tick;
      if (tick) begin
        x_q <= {bus.acc_xh, bus.acc_xl};
        y_q <= {bus.acc_yh, bus.acc_yl};
        z_q <= {bus.acc_zh, bus.acc_zl};
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        ax_q <= abs17(x_q);
        ay_q <= abs17(y_q);
        az_q <= abs17(z_q);
      end
      sample_valid_q <= s2_valid_q;
      if (s2_valid_q) mag_q <= 18'(ax_q) + 18'(ay_q) + 18'(az_q);
    end
  end

  // ---------------------------------------------------------------- beat FSM
  state_t           state_q, state_d;
  logic [17:0]      peak_q, peak_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             beat_q, beat_d;
  logic [17:0]      beat_strength_q, beat_strength_d;
  logic [15:0]      beat_count_q, beat_count_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [17:0]      peak_upd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_ARMED;
      peak_q          <= '0;
      cnt_q           <= '0;
      beat_q          <= 1'b0;
      beat_strength_q <= '0;
      beat_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      peak_q          <= peak_d;
      cnt_q           <= cnt_d;
      beat_q          <= beat_d;
      beat_strength_q <= beat_strength_d;
      beat_count_q    <= beat_count_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d         = state_q;
    peak_d          = peak_q;
    cnt_d           = cnt_q;
    beat_d          = 1'b0;
    beat_strength_d = beat_strength_q;
    beat_count_d    = beat_count_q;
    cnt_inc         = cnt_q + CNT_W'(1);
    peak_upd        = (mag_q > peak_q) ? mag_q : peak_q;

    if (sample_valid_q) begin
      unique case (state_q)
        ST_ARMED: begin
          if (mag_q >= THRESH_ON) begin
            peak_d  = mag_q;
            cnt_d   = '0;
            state_d = ST_PEAK;
          end
        end
        ST_PEAK: begin
          peak_d = peak_upd;
          cnt_d  = cnt_inc;
          // Normal release below THRESH_OFF, or forced once PEAK has lasted PEAK_MAX samples.
          if ((mag_q < THRESH_OFF) || (cnt_inc == CNT_W'(PEAK_MAX))) begin
            beat_d          = 1'b1;
            beat_strength_d = peak_upd;
            beat_count_d    = beat_count_q + 16'd1;
            cnt_d           = '0;
            state_d         = ST_REFRACT;
          end
        end
        ST_REFRACT: begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(REFRACT)) begin
            cnt_d   = '0;
            state_d = ST_ARMED;
          end
        end
        default: state_d = ST_ARMED;
      endcase
    end
  end

  assign bus.sample_valid  = sample_valid_q;
  assign bus.mag           = mag_q;
  assign bus.beat          = beat_q;
  assign bus.beat_strength = beat_strength_q;
  assign bus.beat_count    = beat_count_q;

endmodule
